// File: rtl/l1_ibuf_multiline.sv
// l1_ibuf_multiline: per-thread, NLINES-way fully-associative L1 instruction
// line buffer with same-cycle hits, response bypass and one-outstanding refill.
// Ports: i_clk, i_reset (async, active-high); fetch side i_pcf, i_fetch_tid,
//   o_hit, o_instr; branch hint i_br_valid/i_br_tid/i_br_target; L2 request
//   o_l2_req_valid/i_l2_req_ready/o_l2_req_addr/o_l2_req_spec; L2 response
//   i_l2_rsp_valid/i_l2_rsp_tid/i_l2_rsp_addr/i_l2_rsp_data; o_busy.
// Optional macro L1_IBUF_PERF_EN adds o_perf_hits/o_perf_misses/o_perf_prefetch.
module l1_ibuf_multiline #(
   parameter int               CTID           = 0,
   parameter int               TID_BITS       = 2,
   parameter int               WIDTH          = 32,
   parameter int               NLINES         = 4,
   parameter int               WORDS_PER_LINE = 4,
   parameter logic [WIDTH-1:0] BUBBLE         = 32'h00000013
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic [WIDTH-1:0]              i_pcf,
   input  logic [TID_BITS-1:0]           i_fetch_tid,
   input  logic                          i_br_valid,
   input  logic [TID_BITS-1:0]           i_br_tid,
   input  logic [WIDTH-1:0]              i_br_target,
   output logic                          o_l2_req_valid,
   input  logic                          i_l2_req_ready,
   output logic [WIDTH-1:0]              o_l2_req_addr,
   output logic                          o_l2_req_spec,
   input  logic                          i_l2_rsp_valid,
   input  logic [TID_BITS-1:0]           i_l2_rsp_tid,
   input  logic [WIDTH-1:0]              i_l2_rsp_addr,
   input  logic [WIDTH*WORDS_PER_LINE-1:0] i_l2_rsp_data,
   output logic                          o_hit,
   output logic [WIDTH-1:0]              o_instr,
   output logic                          o_busy
`ifdef L1_IBUF_PERF_EN
   ,
   output logic [31:0]                   o_perf_hits,
   output logic [31:0]                   o_perf_misses,
   output logic [31:0]                   o_perf_prefetch
`endif
);

   localparam int OFF_LSB  = $clog2(WIDTH/8);
   localparam int LINE_LSB = $clog2(WIDTH/8*WORDS_PER_LINE);
   localparam int OFF_W    = LINE_LSB - OFF_LSB;
   localparam int TAG_W    = WIDTH - LINE_LSB;
   localparam int IDX_W    = $clog2(NLINES);
   localparam int LINE_W   = WIDTH*WORDS_PER_LINE;
   localparam logic [OFF_W-1:0]    LAST_OFF = OFF_W'(WORDS_PER_LINE-1);
   localparam logic [TID_BITS-1:0] MY_TID   = TID_BITS'(CTID);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

   state_t              r_state;
   state_t              w_next;
   logic [NLINES-1:0]   r_valid;
   logic [TAG_W-1:0]    r_tag  [NLINES];
   logic [LINE_W-1:0]   r_data [NLINES];
   logic [IDX_W-1:0]    r_vict;
   logic [TAG_W-1:0]    r_pend_tag;
   logic                r_spec;

   logic [TAG_W-1:0]    w_tag;
   logic [OFF_W-1:0]    w_off;
   logic [TAG_W-1:0]    w_br_tag;
   logic [TAG_W-1:0]    w_sq_tag;
   logic [TAG_W-1:0]    w_rsp_tag;
   logic                w_active;
   logic                w_lk_hit;
   logic [WIDTH-1:0]    w_lk_word;
   logic                w_br_pres;
   logic                w_sq_pres;
   logic                w_pend_pres;
   logic [IDX_W-1:0]    w_pend_idx;
   logic                w_inv_found;
   logic [IDX_W-1:0]    w_inv_idx;
   logic                w_fill;
   logic                w_byp;
   logic                w_hit_raw;
   logic                w_dem;
   logic                w_br;
   logic                w_sq;
   logic                w_src;
   logic [TAG_W-1:0]    w_src_tag;
   logic                w_src_spec;
   logic [IDX_W-1:0]    w_fill_idx;
   logic                w_use_vict;
   logic                w_unused;

   assign w_tag     = i_pcf[WIDTH-1:LINE_LSB];
   assign w_off     = i_pcf[LINE_LSB-1:OFF_LSB];
   assign w_br_tag  = i_br_target[WIDTH-1:LINE_LSB];
   // Wraps at the top of the address space.
   assign w_sq_tag  = w_tag + 1'b1;
   assign w_rsp_tag = i_l2_rsp_addr[WIDTH-1:LINE_LSB];
   assign w_active  = (i_fetch_tid == MY_TID);
   assign w_unused  = ^{i_pcf[OFF_LSB-1:0], i_br_target[LINE_LSB-1:0],
                        i_l2_rsp_addr[LINE_LSB-1:0]};

   always_comb begin
      w_lk_hit    = 1'b0;
      w_lk_word   = '0;
      w_br_pres   = 1'b0;
      w_sq_pres   = 1'b0;
      w_pend_pres = 1'b0;
      w_pend_idx  = '0;
      w_inv_found = 1'b0;
      w_inv_idx   = '0;
      for (int i = 0; i < NLINES; i++) begin
         if (r_valid[i] && r_tag[i] == w_tag) begin
            w_lk_hit  = 1'b1;
            w_lk_word = r_data[i][w_off*WIDTH +: WIDTH];
         end
         if (r_valid[i] && r_tag[i] == w_br_tag) w_br_pres = 1'b1;
         if (r_valid[i] && r_tag[i] == w_sq_tag) w_sq_pres = 1'b1;
         if (r_valid[i] && r_tag[i] == r_pend_tag) begin
            w_pend_pres = 1'b1;
            w_pend_idx  = IDX_W'(i);
         end
         if (!r_valid[i] && !w_inv_found) begin
            w_inv_found = 1'b1;
            w_inv_idx   = IDX_W'(i);
         end
      end
   end

   // Only an outstanding request for our thread and line completes a fill.
   assign w_fill = (r_state == S_WAIT) && i_l2_rsp_valid &&
                   (i_l2_rsp_tid == MY_TID) && (w_rsp_tag == r_pend_tag);
   assign w_byp     = w_fill && (w_tag == r_pend_tag);
   assign w_hit_raw = w_active && (w_lk_hit || w_byp);

   assign o_hit   = !i_reset && w_hit_raw;
   assign o_instr = !o_hit ? BUBBLE :
                    w_byp  ? i_l2_rsp_data[w_off*WIDTH +: WIDTH] :
                             w_lk_word;

   assign w_dem = w_active && !w_hit_raw;
   assign w_br  = i_br_valid && (i_br_tid == MY_TID) && !w_br_pres;
   assign w_sq  = w_hit_raw && (w_off == LAST_OFF) && !w_sq_pres;
   assign w_src = w_dem || w_br || w_sq;

   always_comb begin
      w_src_tag  = w_sq_tag;
      w_src_spec = 1'b1;
      if (w_dem) begin
         w_src_tag  = w_tag;
         w_src_spec = 1'b0;
      end else if (w_br) begin
         w_src_tag  = w_br_tag;
      end
   end

   assign w_use_vict = !w_pend_pres && !w_inv_found;
   assign w_fill_idx = w_pend_pres ? w_pend_idx :
                       w_inv_found ? w_inv_idx  : r_vict;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_src)          w_next = S_REQ;
         S_REQ:   if (i_l2_req_ready) w_next = S_WAIT;
         S_WAIT:  if (w_fill)         w_next = S_IDLE;
         default:                     w_next = S_IDLE;
      endcase
   end

   always_comb begin
      o_l2_req_valid = (r_state == S_REQ);
      o_busy         = (r_state != S_IDLE);
   end

   assign o_l2_req_addr = {r_pend_tag, {LINE_LSB{1'b0}}};
   assign o_l2_req_spec = r_spec;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_valid    <= '0;
         r_vict     <= '0;
         r_pend_tag <= '0;
         r_spec     <= 1'b0;
         for (int i = 0; i < NLINES; i++) r_tag[i] <= '0;
      end else begin
         if (r_state == S_IDLE && w_src) begin
            r_pend_tag <= w_src_tag;
            r_spec     <= w_src_spec;
         end
         if (w_fill) begin
            r_valid[w_fill_idx] <= 1'b1;
            r_tag[w_fill_idx]   <= r_pend_tag;
            if (w_use_vict) r_vict <= r_vict + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_fill) r_data[w_fill_idx] <= i_l2_rsp_data;
   end

`ifdef L1_IBUF_PERF_EN
   logic w_acc_spec;
   assign w_acc_spec = o_l2_req_valid && i_l2_req_ready && r_spec;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_perf_hits     <= '0;
         o_perf_misses   <= '0;
         o_perf_prefetch <= '0;
      end else begin
         if (w_hit_raw && o_perf_hits != '1)
            o_perf_hits <= o_perf_hits + 1'b1;
         if (w_dem && o_perf_misses != '1)
            o_perf_misses <= o_perf_misses + 1'b1;
         if (w_acc_spec && o_perf_prefetch != '1)
            o_perf_prefetch <= o_perf_prefetch + 1'b1;
      end
   end
`endif

endmodule
